// File: rtl/lc3b_mem_responder.sv
// Memory-side responder for the lc3b memory handshake: word-wide array with byte-lane writes.
// Latency: mem_resp pulses LATENCY cycles after the request is first sampled, for exactly one cycle.
// Backpressure: none; the initiator holds its request until mem_resp, and dropping it early aborts the op.
module lc3b_mem_responder #(
    parameter int LATENCY   = 2,   // 1..15
    parameter int ADDR_BITS = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic [1:0]  mem_byte_enable,
    output logic        mem_resp,
    output logic [15:0] mem_rdata,
    output logic        busy,
    output logic        proto_err
);

    localparam int         DEPTH    = 1 << ADDR_BITS;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [15:0]            wdata_q, wdata_d;
    logic [1:0]             be_q, be_d;
    logic                   wr_q, wr_d;
    logic                   resp_q, resp_d;
    logic [15:0]            rdata_q, rdata_d;
    logic                   busy_q, busy_d;
    logic                   perr_q, perr_d;

    // Operation that completes on the edge entering RESP. With LATENCY==1 this
    // is the sampling edge itself, so the live inputs are used instead of the
    // captured copies.
    logic                   enter_resp;
    logic                   cm_write;
    logic [ADDR_BITS-1:0]   cm_idx;
    logic [15:0]            cm_wdata;
    logic [1:0]             cm_be;
    logic                   mem_we;
    logic                   req;

    logic [15:0]            mem_array [DEPTH];

    // Address bits above the word index and the byte-select bit do not select a word.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{mem_address[15:ADDR_BITS+1], mem_address[0]};

    assign req = mem_read | mem_write;

    // Next-state, capture and completion decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        wr_d       = wr_q;
        perr_d     = perr_q;
        enter_resp = 1'b0;
        cm_write   = wr_q;
        cm_idx     = addr_q;
        cm_wdata   = wdata_q;
        cm_be      = be_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d  = mem_address[ADDR_BITS:1];
                    wdata_d = mem_wdata;
                    be_d    = mem_byte_enable;
                    // A simultaneous read and write is handled as a write.
                    wr_d    = mem_write;
                    cnt_d   = CNT_INIT;
                    if (mem_read && mem_write) begin
                        perr_d = 1'b1;
                    end
                    if (LATENCY == 1) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                        cm_write   = mem_write;
                        cm_idx     = mem_address[ADDR_BITS:1];
                        cm_wdata   = mem_wdata;
                        cm_be      = mem_byte_enable;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                // Abort is checked first so it wins over the final countdown step.
                if (!req) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd1) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                    cnt_d      = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                // Nothing is sampled here; the response completes even if the request dropped.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Registered outputs follow the next state so they line up with it.
    always_comb begin
        resp_d  = enter_resp;
        busy_d  = (state_d != IDLE);
        rdata_d = 16'h0000;
        if (enter_resp && !cm_write) begin
            rdata_d = mem_array[cm_idx];
        end
    end

    assign mem_we = enter_resp && cm_write;

    // Control and output registers; the array itself is not reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= 16'h0000;
            be_q    <= 2'b00;
            wr_q    <= 1'b0;
            resp_q  <= 1'b0;
            rdata_q <= 16'h0000;
            busy_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            wr_q    <= wr_d;
            resp_q  <= resp_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            perr_q  <= perr_d;
        end
    end

    // Per-lane write commit; held off while reset is asserted so a killed write never lands.
    always_ff @(posedge clk) begin
        if (mem_we && rst_n) begin
            if (cm_be[0]) begin
                mem_array[cm_idx][7:0] <= cm_wdata[7:0];
            end
            if (cm_be[1]) begin
                mem_array[cm_idx][15:8] <= cm_wdata[15:8];
            end
        end
    end

    assign mem_resp  = resp_q;
    assign mem_rdata = rdata_q;
    assign busy      = busy_q;
    assign proto_err = perr_q;

endmodule

// File: tb/tb_lc3b_mem_responder.sv
// Bench for lc3b_mem_responder: three instances with LATENCY 1, 2 and 3.
// Directed scenarios plus randomized transactions checked against a word-array model.
// Each instance is driven by its own request signals, one transaction at a time.
module tb_lc3b_mem_responder;

    logic        clk;
    logic        rst_n;
    logic        rd     [3];
    logic        wr     [3];
    logic [15:0] ad     [3];
    logic [15:0] wdv    [3];
    logic [1:0]  bev    [3];
    logic        resp_o [3];
    logic [15:0] rdata_o[3];
    logic        busy_o [3];
    logic        perr_o [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        lc3b_mem_responder #(
            .LATENCY   (g + 1),
            .ADDR_BITS (10)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .mem_read        (rd[g]),
            .mem_write       (wr[g]),
            .mem_address     (ad[g]),
            .mem_wdata       (wdv[g]),
            .mem_byte_enable (bev[g]),
            .mem_resp        (resp_o[g]),
            .mem_rdata       (rdata_o[g]),
            .busy            (busy_o[g]),
            .proto_err       (perr_o[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] ref_mem  [3][1024];
    bit          ref_perr [3];
    logic [9:0]  pool     [16];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One transaction on instance d (latency d+1). abort_at>0 drops the request
    // during cycle abort_at. Called and returns at posedge+1 with instance idle.
    task automatic txn(input int d, input bit r, input bit w, input logic [15:0] a,
                       input logic [15:0] wd, input logic [1:0] be, input int abort_at);
        int          lat;
        logic [9:0]  idx;
        logic [15:0] exp_rd;
        lat    = d + 1;
        idx    = a[10:1];
        exp_rd = (r && !w) ? ref_mem[d][idx] : 16'h0000;
        if (r && w) ref_perr[d] = 1'b1;
        rd[d] = r; wr[d] = w; ad[d] = a; wdv[d] = wd; bev[d] = be;
        if (abort_at > 0) begin
            for (int k = 1; k <= abort_at; k++) begin
                @(posedge clk); #1;
                chk("abort_wait_resp", 32'(resp_o[d]), 32'd0);
                chk("abort_wait_busy", 32'(busy_o[d]), 32'd1);
            end
            rd[d] = 1'b0; wr[d] = 1'b0;
            for (int k = 0; k <= lat; k++) begin
                @(posedge clk); #1;
                chk("abort_resp", 32'(resp_o[d]), 32'd0);
                chk("abort_busy", 32'(busy_o[d]), 32'd0);
            end
        end else begin
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk); #1;
                if (k < lat) begin
                    chk("wait_resp", 32'(resp_o[d]), 32'd0);
                    chk("wait_busy", 32'(busy_o[d]), 32'd1);
                    chk("wait_rdata", 32'(rdata_o[d]), 32'd0);
                    // Captured values must be used; scramble the live inputs.
                    ad[d]  = 16'($urandom);
                    wdv[d] = 16'($urandom);
                    bev[d] = 2'($urandom);
                end else begin
                    chk("resp", 32'(resp_o[d]), 32'd1);
                    chk("resp_rdata", 32'(rdata_o[d]), 32'(exp_rd));
                    chk("resp_busy", 32'(busy_o[d]), 32'd1);
                    chk("proto_err", 32'(perr_o[d]), 32'(ref_perr[d]));
                end
            end
            if (w) begin
                if (be[0]) ref_mem[d][idx][7:0]  = wd[7:0];
                if (be[1]) ref_mem[d][idx][15:8] = wd[15:8];
            end
            rd[d] = 1'b0; wr[d] = 1'b0;
            @(posedge clk); #1;
            chk("post_resp", 32'(resp_o[d]), 32'd0);
            chk("post_rdata", 32'(rdata_o[d]), 32'd0);
            chk("post_busy", 32'(busy_o[d]), 32'd0);
        end
    endtask

    task automatic chk_idle_all(input string tag);
        for (int d = 0; d < 3; d++) begin
            chk({tag, "_resp"},  32'(resp_o[d]),  32'd0);
            chk({tag, "_rdata"}, 32'(rdata_o[d]), 32'd0);
            chk({tag, "_busy"},  32'(busy_o[d]),  32'd0);
            chk({tag, "_perr"},  32'(perr_o[d]),  32'(ref_perr[d]));
        end
    endtask

    function automatic logic [15:0] rand_addr(input logic [9:0] w);
        return {5'($urandom), w, 1'($urandom)};
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; ad[d] = '0; wdv[d] = '0; bev[d] = '0;
            ref_perr[d] = 1'b0;
        end
        for (int k = 0; k < 16; k++) pool[k] = 10'((k * 67 + 5) % 1024);
        repeat (3) @(posedge clk);
        #1;
        chk_idle_all("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency 2: write/read, lane masks, empty mask, alias, protocol error.
        txn(1, 0, 1, 16'h0040, 16'hBEEF, 2'b11, 0);
        txn(1, 1, 0, 16'h0040, 16'h0000, 2'b00, 0);
        chk("model_beef", 32'(ref_mem[1][10'h020]), 32'h0000BEEF);
        txn(1, 0, 1, 16'h0041, 16'h1200, 2'b10, 0);
        txn(1, 1, 0, 16'h0040, 16'h0000, 2'b00, 0);
        txn(1, 0, 1, 16'h0040, 16'hFFFF, 2'b00, 0);
        txn(1, 1, 0, 16'h0040, 16'h0000, 2'b00, 0);
        txn(1, 0, 1, 16'h0802, 16'h5A5A, 2'b11, 0);
        txn(1, 1, 0, 16'h0002, 16'h0000, 2'b00, 0);
        txn(1, 1, 1, 16'h0100, 16'h7777, 2'b11, 0);
        txn(1, 1, 0, 16'h0100, 16'h0000, 2'b00, 0);

        // Latency 3: aborts in the first wait cycle and on the would-be RESP edge.
        txn(2, 0, 1, 16'h0040, 16'hBEEF, 2'b11, 0);
        txn(2, 1, 0, 16'h0040, 16'h0000, 2'b00, 1);
        txn(2, 0, 1, 16'h0040, 16'hFFFF, 2'b11, 1);
        txn(2, 0, 1, 16'h0040, 16'hFFFF, 2'b11, 2);
        txn(2, 1, 0, 16'h0040, 16'h0000, 2'b00, 0);

        // Initialise the random pool on every instance.
        for (int d = 0; d < 3; d++)
            for (int k = 0; k < 16; k++)
                txn(d, 0, 1, rand_addr(pool[k]), 16'($urandom), 2'b11, 0);

        // Latency 1: reads held continuously -> responses every other cycle.
        rd[0] = 1'b1;
        ad[0] = {5'd0, pool[0], 1'b0};
        for (int n = 0; n < 3; n++) begin
            @(posedge clk); #1;
            chk("b2b_resp", 32'(resp_o[0]), 32'd1);
            chk("b2b_rdata", 32'(rdata_o[0]), 32'(ref_mem[0][pool[n]]));
            ad[0] = {5'd0, pool[n + 1], 1'b0};
            @(posedge clk); #1;
            chk("b2b_gap_resp", 32'(resp_o[0]), 32'd0);
            chk("b2b_gap_rdata", 32'(rdata_o[0]), 32'd0);
            chk("b2b_gap_busy", 32'(busy_o[0]), 32'd0);
        end
        rd[0] = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic on every instance.
        for (int d = 0; d < 3; d++) begin
            for (int n = 0; n < 60; n++) begin
                int          sel;
                logic [15:0] a;
                sel = $urandom_range(0, 9);
                a   = rand_addr(pool[$urandom_range(0, 15)]);
                if (sel <= 3 || (sel == 9 && d == 0))
                    txn(d, 1, 0, a, 16'($urandom), 2'($urandom), 0);
                else if (sel <= 7)
                    txn(d, 0, 1, a, 16'($urandom), 2'($urandom), 0);
                else if (sel == 8)
                    txn(d, 1, 1, a, 16'($urandom), 2'($urandom), 0);
                else if ($urandom_range(0, 1) == 0)
                    txn(d, 1, 0, a, 16'($urandom), 2'($urandom), $urandom_range(1, d));
                else
                    txn(d, 0, 1, a, 16'($urandom), 2'($urandom), $urandom_range(1, d));
            end
        end

        // Reset during the wait of a write: outputs clear at once, write is lost.
        txn(2, 0, 1, 16'h0010, 16'h2222, 2'b11, 0);
        wr[2] = 1'b1; ad[2] = 16'h0010; wdv[2] = 16'h1111; bev[2] = 2'b11;
        @(posedge clk); #1;
        chk("rst_wait_busy", 32'(busy_o[2]), 32'd1);
        #2;
        rst_n = 1'b0;
        for (int d = 0; d < 3; d++) ref_perr[d] = 1'b0;
        #1;
        chk_idle_all("async_rst");
        wr[2] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        txn(2, 1, 0, 16'h0010, 16'h0000, 2'b00, 0);
        chk("rst_kept_word", 32'(ref_mem[2][10'h008]), 32'h00002222);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
